// File: rtl/shift_right_transmitter_pkg.sv
// ============================================================================
// Module      : shift_right_transmitter_pkg
// Description : Shared state encoding and last-count helper for the
//               shift-right transmitter. Honours SHIFT_RIGHT_TRANSMITTER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_right_transmitter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Counter value at which the final bit of a word is on the line.
    function automatic int last_count(input int bits);
`ifdef SHIFT_RIGHT_TRANSMITTER_PARITY_EN
        return bits;
`else
        return bits - 1;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_right_transmitter_bit_counter.sv
// ============================================================================
// Module      : bit_counter
// Description : Terminal-count up counter; saturates at LAST, cleared by
//               i_clr or i_sclr. Reusable by receive/UART blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_counter #(
    parameter int WIDTH = 3,
    parameter int LAST  = 4
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_sclr,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_last
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(LAST);

    logic [WIDTH-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_sclr || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = w_last;

endmodule

`default_nettype wire

// File: rtl/shift_right_transmitter.sv
// ============================================================================
// Module      : shift_right_transmitter
// Description : Parallel-in / serial-out transmitter, LSB first, with
//               load/ready handshake. Optional even parity bit when
//               SHIFT_RIGHT_TRANSMITTER_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_right_transmitter
    import shift_right_transmitter_pkg::*;
#(
    parameter int BITS  = 5,
    parameter int CNT_W = $clog2(BITS + 1)
) (
    input  logic            clk,
    input  logic            i_rst_n,
    input  logic            i_sclr,
    input  logic            i_load,
    input  logic [BITS-1:0] i_data,
    input  logic            i_en,
    output logic            o_dat,
    output logic            o_valid,
    output logic            o_ready,
    output logic            o_done
);

    localparam int LAST = last_count(BITS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BITS-1:0]   r_shift;
    logic [BITS-1:0]   w_shift_nxt;
    logic              r_done;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_last;
    logic              w_load_acc;
    logic              w_step;
    logic              w_final;

    assign w_load_acc = (r_state == ST_IDLE)  && i_load;
    assign w_step     = (r_state == ST_SHIFT) && i_en;
    assign w_final    = w_step && w_last;

    bit_counter #(
        .WIDTH (CNT_W),
        .LAST  (LAST)
    ) u_bit_counter (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_sclr  (i_sclr),
        .i_clr   (w_load_acc || w_final),
        .i_en    (w_step),
        .o_cnt   (w_cnt),
        .o_last  (w_last)
    );

`ifdef SHIFT_RIGHT_TRANSMITTER_PARITY_EN
    localparam logic [CNT_W-1:0] c_DATA_LAST = CNT_W'(BITS - 1);

    logic r_parity;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parity <= 1'b0;
        end else if (i_sclr) begin
            r_parity <= 1'b0;
        end else if (w_load_acc) begin
            r_parity <= ^i_data;
        end
    end
`else
    logic w_unused_cnt;
    assign w_unused_cnt = ^w_cnt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_load)            w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (i_en && w_last)    w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_shift_nxt = r_shift;
        if (w_load_acc) begin
            w_shift_nxt = i_data;
        end else if (w_final) begin
            w_shift_nxt = '0;
        end else if (w_step) begin
            w_shift_nxt = r_shift >> 1;
`ifdef SHIFT_RIGHT_TRANSMITTER_PARITY_EN
            // After the last data bit the parity bit takes its place on the line.
            if (w_cnt == c_DATA_LAST) begin
                w_shift_nxt = {{(BITS-1){1'b0}}, r_parity};
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_done  <= 1'b0;
        end else if (i_sclr) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_done  <= w_final;
        end
    end

    assign o_dat   = r_shift[0];
    assign o_valid = (r_state == ST_SHIFT);
    assign o_ready = (r_state == ST_IDLE);
    assign o_done  = r_done;

endmodule

`default_nettype wire

// File: doc/shift_right_transmitter.md
Name: shift_right_transmitter

Overview:
- Parallel-in / serial-out companion to the shift-right receive register: loads a BITS-wide word and emits it one bit per enabled clock, LSB first.
- A shift-right receiver fed with `o_dat` reassembles the original word after BITS enabled clocks.
- Sits at the transmit end of the serial link; upstream logic hands words over with a load/ready handshake.

Parameters:
- BITS, 5, word width in bits (>= 2).
- CNT_W, $clog2(BITS+1), bit-counter width, derived; never overridden.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_sclr  input  1  synchronous clear: same effect as reset, applied at posedge; priority over every input except i_rst_n.
- i_load  input  1  request to load i_data; accepted only while o_ready=1.
- i_data  input  BITS  parallel word to transmit.
- i_en  input  1  shift enable: advances one bit when o_valid=1; stalls when 0.
- o_dat  output  1  serial data bit, equal to the LSB of the shift register.
- o_valid  output  1  o_dat carries a valid bit.
- o_ready  output  1  idle, able to accept a load.
- o_done  output  1  one-cycle pulse after the final bit is consumed.

Behaviour:
- Reset (i_rst_n=0, asynchronous) or i_sclr=1 at posedge:
  - state=IDLE, shift register=0, counter=0.
  - o_dat=0, o_valid=0, o_ready=1, o_done=0.
- State IDLE:
  - o_ready=1, o_valid=0, o_dat=0.
  - On posedge with i_load=1: shift register<=i_data, counter<=0, state<=SHIFT.
  - From the next cycle: o_valid=1, o_dat=i_data[0]. Load-to-first-bit latency is 1 clock.
- State SHIFT:
  - o_ready=0, o_valid=1.
  - Posedge with i_en=1 and counter<BITS-1: register shifts right, MSB filled with 0, counter+1. o_dat then shows the next bit.
  - Posedge with i_en=1 and counter==BITS-1: state<=IDLE, register<=0, o_done=1 for exactly that following cycle.
  - Posedge with i_en=0: hold everything. Stalls are unlimited.
- Bits emitted in order: i_data[0], i_data[1], …, i_data[BITS-1]. Each bit is held until consumed by an enabled clock.
- i_load while in SHIFT is ignored, and i_data is not sampled.
- i_load in the same cycle as the final shift is ignored: no back-to-back. The next load is accepted at the earliest on the following cycle, when o_ready=1 and o_done=1 together.
- i_sclr mid-word aborts the transfer: no o_done, next cycle is IDLE.
- Async reset mid-word: outputs go to reset values immediately, without waiting for clk.
- Counter never wraps: it leaves SHIFT at BITS-1.

Optional Feature:
- Macro: SHIFT_RIGHT_TRANSMITTER_PARITY_EN.
- With the macro defined:
  - After bit BITS-1, one extra bit is emitted: even parity, the XOR of all BITS data bits latched at load.
  - The parity bit is consumed by one more enabled clock. o_done pulses after the parity bit, not after bit BITS-1.
  - Total enabled clocks per word: BITS+1.
- Without the macro: no parity bit, BITS enabled clocks per word, and no parity logic is synthesised.

Decomposition:
- Shared header/package contents:
  - State encodings: ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - A localparam helper for the last count: BITS-1, or BITS with the parity macro.
- One natural sub-module, bit_counter:
  - Ports: clk, i_rst_n, i_sclr, i_clr, i_en, o_cnt, o_last.
  - A terminal-count counter, reusable by future receive/UART blocks.
- The shift register and FSM stay in the top module.

Test Plan:
1. Reset and idle:
   - Stimulus: assert i_rst_n=0 mid-cycle.
   - Response: o_valid=0, o_ready=1, o_dat=0, o_done=0 immediately; unchanged over 3 clocks with i_load=0.
2. Basic word, BITS=5:
   - Stimulus: load 5'b11101, then i_en=1 continuously.
   - Response: o_dat over consecutive cycles = 1,0,1,1,1; o_done=1 on the 6th cycle after load; o_ready=1 on that same cycle.
3. Stall:
   - Stimulus: load 5'b01010, i_en=0 for 3 cycles after the first shift.
   - Response: o_dat held at 1 (bit1) and o_valid=1 throughout; the remaining sequence 0,1,0 resumes when i_en=1.
4. Ignored loads:
   - Stimulus: load 5'b00001, then pulse i_load with 5'b11111 during SHIFT and during the final shift.
   - Response: sequence is exactly 1,0,0,0,0 and the second word is never transmitted.
5. Abort:
   - Stimulus: i_sclr=1 after 2 bits of 5'b10110.
   - Response: next cycle o_valid=0, o_ready=1, o_done never pulses; a following load of 5'b00011 transmits 1,1,0,0,0 cleanly.
6. Loopback:
   - Stimulus: connect o_dat to a shift_right_register's i_dat and o_valid&i_en to its i_en; load 5'b10011.
   - Response: receiver o_data==5'b10011 on the cycle o_done=1.
   - With SHIFT_RIGHT_TRANSMITTER_PARITY_EN defined, the 6th bit observed = 1.
